// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states, error codes
// and the alignment rule shared by request decode and any user of it.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    typedef enum logic {
        ERR_NONE     = 1'b0,
        ERR_MISALIGN = 1'b1
    } err_e;

    // Reserved size is reported the same way as a misaligned access.
    function automatic err_e check_align(input logic [1:0] size, input logic [1:0] addr_lo);
        err_e err;
        case (size)
            SIZE_BYTE: err = ERR_NONE;
            SIZE_HALF: err = addr_lo[0] ? ERR_MISALIGN : ERR_NONE;
            SIZE_WORD: err = (addr_lo != 2'b00) ? ERR_MISALIGN : ERR_NONE;
            default:   err = ERR_MISALIGN;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the byte/half lane of a memory word and
// sign- or zero-extends it to 32 bits.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_lane = word[7:0];
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        data      = word;
        case (addr_lo)
            2'b00:   byte_lane = word[7:0];
            2'b01:   byte_lane = word[15:8];
            2'b10:   byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        case (size)
            SIZE_BYTE: data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            SIZE_HALF: data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-requester (core, debug/loader) data-memory controller: round-robin grant,
// one-cycle memory access, one-cycle response. Debug arbitration: DMEM_CTRL_DBG_PORT_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_AW = 15
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_we,
    input  logic [1:0]        core_req_size,
    input  logic              core_req_unsigned,
    input  logic [MEM_AW+1:0] core_req_addr,
    input  logic [31:0]       core_req_wdata,
    output logic              core_rsp_valid,
    output logic              core_rsp_err,

    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [1:0]        dbg_req_size,
    input  logic              dbg_req_unsigned,
    input  logic [MEM_AW+1:0] dbg_req_addr,
    input  logic [31:0]       dbg_req_wdata,
    output logic              dbg_rsp_valid,
    output logic              dbg_rsp_err,

    output logic [31:0]       rsp_rdata,

    output logic              mem_read_ctrl,
    output logic              mem_write_ctrl,
    output logic              B,
    output logic              H,
    output logic [MEM_AW-1:0] mem_address,
    output logic [1:0]        addr_allign,
    output logic [31:0]       mem_data_write,
    input  logic [31:0]       mem_data_read
);

    state_e            state_q, state_d;
    logic              prio_dbg_q, prio_dbg_d;
    logic              port_dbg_q, port_dbg_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    err_e              err_q, err_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              b_q, b_d;
    logic              h_q, h_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic              dbg_valid;
    logic              grant_dbg;
    logic              sel_valid;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [MEM_AW+1:0] sel_addr;
    logic [31:0]       sel_wdata;
    err_e              sel_err;
    logic [31:0]       load_data;

`ifdef DMEM_CTRL_DBG_PORT_EN
    assign dbg_valid = dbg_req_valid;
`else
    logic unused_dbg_valid;
    assign unused_dbg_valid = dbg_req_valid;
    assign dbg_valid        = 1'b0;
`endif

    // Debug wins only if core is idle or core was served last.
    assign grant_dbg = dbg_valid & (~core_req_valid | prio_dbg_q);
    assign sel_valid = grant_dbg ? dbg_valid        : core_req_valid;
    assign sel_we    = grant_dbg ? dbg_req_we       : core_req_we;
    assign sel_size  = grant_dbg ? dbg_req_size     : core_req_size;
    assign sel_uns   = grant_dbg ? dbg_req_unsigned : core_req_unsigned;
    assign sel_addr  = grant_dbg ? dbg_req_addr     : core_req_addr;
    assign sel_wdata = grant_dbg ? dbg_req_wdata    : core_req_wdata;
    assign sel_err   = check_align(sel_size, sel_addr[1:0]);

    load_align u_load_align (
        .word        (mem_data_read),
        .size        (size_q),
        .addr_lo     (addr_lo_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    always_comb begin
        state_d     = state_q;
        prio_dbg_d  = prio_dbg_q;
        port_dbg_d  = port_dbg_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        err_d       = err_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        b_d         = b_q;
        h_d         = h_q;
        mem_addr_d  = mem_addr_q;
        addr_lo_d   = addr_lo_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d     = ST_ACCESS;
                    port_dbg_d  = grant_dbg;
                    prio_dbg_d  = ~grant_dbg;
                    we_d        = sel_we;
                    size_d      = sel_size;
                    uns_d       = sel_uns;
                    err_d       = sel_err;
                    mem_rd_d    = ~sel_we & (sel_err == ERR_NONE);
                    mem_wr_d    = sel_we & (sel_err == ERR_NONE);
                    b_d         = (sel_size == SIZE_BYTE);
                    h_d         = (sel_size == SIZE_HALF);
                    mem_addr_d  = sel_addr[MEM_AW+1:2];
                    addr_lo_d   = sel_addr[1:0];
                    mem_wdata_d = sel_wdata;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = (err_q == ERR_MISALIGN);
                rsp_rdata_d = (we_q || err_q == ERR_MISALIGN) ? 32'h0 : load_data;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prio_dbg_q  <= 1'b0;
            port_dbg_q  <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            err_q       <= ERR_NONE;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            b_q         <= 1'b0;
            h_q         <= 1'b0;
            mem_addr_q  <= '0;
            addr_lo_q   <= 2'b00;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            prio_dbg_q  <= prio_dbg_d;
            port_dbg_q  <= port_dbg_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            b_q         <= b_d;
            h_q         <= h_d;
            mem_addr_q  <= mem_addr_d;
            addr_lo_q   <= addr_lo_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign core_req_ready = (state_q == ST_IDLE) & ~grant_dbg;
    assign core_rsp_valid = rsp_valid_q & ~port_dbg_q;
    assign core_rsp_err   = rsp_err_q & ~port_dbg_q;

`ifdef DMEM_CTRL_DBG_PORT_EN
    assign dbg_req_ready  = (state_q == ST_IDLE) & grant_dbg;
    assign dbg_rsp_valid  = rsp_valid_q & port_dbg_q;
    assign dbg_rsp_err    = rsp_err_q & port_dbg_q;
`else
    assign dbg_req_ready  = 1'b0;
    assign dbg_rsp_valid  = 1'b0;
    assign dbg_rsp_err    = 1'b0;
`endif

    assign rsp_rdata      = rsp_rdata_q;
    assign mem_read_ctrl  = mem_rd_q;
    assign mem_write_ctrl = mem_wr_q;
    assign B              = b_q;
    assign H              = h_q;
    assign mem_address    = mem_addr_q;
    assign addr_allign    = addr_lo_q;
    assign mem_data_write = mem_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random traffic scored
// against a lane-arithmetic reference model of the load/store rules.
module tb_dmem_ctrl;

    localparam int MEM_AW = 15;
`ifdef DMEM_CTRL_DBG_PORT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              core_req_valid = 1'b0, core_req_ready, core_req_we = 1'b0, core_req_unsigned = 1'b0;
    logic [1:0]        core_req_size = 2'b00;
    logic [MEM_AW+1:0] core_req_addr = '0;
    logic [31:0]       core_req_wdata = 32'h0;
    logic              core_rsp_valid, core_rsp_err;
    logic              dbg_req_valid = 1'b0, dbg_req_ready, dbg_req_we = 1'b0, dbg_req_unsigned = 1'b0;
    logic [1:0]        dbg_req_size = 2'b00;
    logic [MEM_AW+1:0] dbg_req_addr = '0;
    logic [31:0]       dbg_req_wdata = 32'h0;
    logic              dbg_rsp_valid, dbg_rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_read_ctrl, mem_write_ctrl, B, H;
    logic [MEM_AW-1:0] mem_address;
    logic [1:0]        addr_allign;
    logic [31:0]       mem_data_write;
    logic [31:0]       mem_data_read = 32'h0;

    logic [31:0] mem_model [64];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_we(core_req_we),
        .core_req_size(core_req_size), .core_req_unsigned(core_req_unsigned), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata), .core_rsp_valid(core_rsp_valid), .core_rsp_err(core_rsp_err),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_we(dbg_req_we),
        .dbg_req_size(dbg_req_size), .dbg_req_unsigned(dbg_req_unsigned), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_err(dbg_rsp_err),
        .rsp_rdata(rsp_rdata),
        .mem_read_ctrl(mem_read_ctrl), .mem_write_ctrl(mem_write_ctrl), .B(B), .H(H),
        .mem_address(mem_address), .addr_allign(addr_allign), .mem_data_write(mem_data_write),
        .mem_data_read(mem_data_read)
    );

    // Memory returns the addressed word on the falling edge of a read cycle, junk otherwise.
    always @(negedge clk) begin
        if (mem_read_ctrl) mem_data_read = mem_model[mem_address[5:0]];
        else               mem_data_read = $urandom;
    end

    function automatic bit ref_err(input int size, input int lo);
        return (size == 3) || (size == 1 && (lo % 2) == 1) || (size == 2 && lo != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int size, input int lo, input bit uns);
        logic [31:0] v;
        if (size == 0) begin
            v = (w >> (8 * lo)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (w >> (16 * (lo / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Full transaction on one port: request, ACCESS-cycle memory checks, RESP checks, hold checks.
    task automatic run_txn(input bit is_dbg, input bit we, input logic [1:0] size, input bit uns,
                           input logic [MEM_AW+1:0] addr, input logic [31:0] wdata, input string tag);
        bit ok;
        bit err;
        logic [31:0] exp_rdata;
        int lo;
        lo  = int'(addr[1:0]);
        err = ref_err(int'(size), lo);
        @(negedge clk);
        if (is_dbg) begin
            dbg_req_valid = 1'b1; dbg_req_we = we; dbg_req_size = size;
            dbg_req_unsigned = uns; dbg_req_addr = addr; dbg_req_wdata = wdata;
        end else begin
            core_req_valid = 1'b1; core_req_we = we; core_req_size = size;
            core_req_unsigned = uns; core_req_addr = addr; core_req_wdata = wdata;
        end
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if ((is_dbg ? dbg_req_ready : core_req_ready) === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s accept: ready never seen, required ready=1 within 20 cycles", tag);
            core_req_valid = 1'b0; dbg_req_valid = 1'b0;
            return;
        end
        exp_rdata = (we || err) ? 32'h0 : ref_load(mem_model[addr[7:2]], int'(size), lo, uns);
        @(posedge clk); #1;
        core_req_valid = 1'b0; dbg_req_valid = 1'b0;
        n_cmp++; if (mem_read_ctrl !== (!we && !err)) begin n_bad++; $display("FAIL %s rd_strobe: got %b want %b", tag, mem_read_ctrl, !we && !err); end
        n_cmp++; if (mem_write_ctrl !== (we && !err)) begin n_bad++; $display("FAIL %s wr_strobe: got %b want %b", tag, mem_write_ctrl, we && !err); end
        n_cmp++; if ((core_rsp_valid | dbg_rsp_valid) !== 1'b0) begin n_bad++; $display("FAIL %s early_rsp: got %b want 0", tag, core_rsp_valid | dbg_rsp_valid); end
        if (!err) begin
            n_cmp++; if (B !== (size == 2'b00)) begin n_bad++; $display("FAIL %s B: got %b want %b", tag, B, size == 2'b00); end
            n_cmp++; if (H !== (size == 2'b01)) begin n_bad++; $display("FAIL %s H: got %b want %b", tag, H, size == 2'b01); end
            n_cmp++; if (mem_address !== addr[MEM_AW+1:2]) begin n_bad++; $display("FAIL %s mem_address: got %0h want %0h", tag, mem_address, addr[MEM_AW+1:2]); end
            n_cmp++; if (addr_allign !== addr[1:0]) begin n_bad++; $display("FAIL %s addr_allign: got %b want %b", tag, addr_allign, addr[1:0]); end
            if (we) begin
                n_cmp++; if (mem_data_write !== wdata) begin n_bad++; $display("FAIL %s wdata: got %h want %h", tag, mem_data_write, wdata); end
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (core_rsp_valid !== !is_dbg) begin n_bad++; $display("FAIL %s core_rsp_valid: got %b want %b", tag, core_rsp_valid, !is_dbg); end
        n_cmp++; if (dbg_rsp_valid !== is_dbg) begin n_bad++; $display("FAIL %s dbg_rsp_valid: got %b want %b", tag, dbg_rsp_valid, is_dbg); end
        n_cmp++; if ((is_dbg ? dbg_rsp_err : core_rsp_err) !== err) begin n_bad++; $display("FAIL %s rsp_err: got %b want %b", tag, is_dbg ? dbg_rsp_err : core_rsp_err, err); end
        n_cmp++; if (rsp_rdata !== exp_rdata) begin n_bad++; $display("FAIL %s rdata: got %h want %h", tag, rsp_rdata, exp_rdata); end
        n_cmp++; if ((mem_read_ctrl | mem_write_ctrl) !== 1'b0) begin n_bad++; $display("FAIL %s resp_strobe: got %b want 0", tag, mem_read_ctrl | mem_write_ctrl); end
        @(posedge clk); #1;
        n_cmp++; if ((core_rsp_valid | dbg_rsp_valid) !== 1'b0) begin n_bad++; $display("FAIL %s rsp_one_cycle: got %b want 0", tag, core_rsp_valid | dbg_rsp_valid); end
        n_cmp++; if (rsp_rdata !== exp_rdata) begin n_bad++; $display("FAIL %s rdata_hold: got %h want %h", tag, rsp_rdata, exp_rdata); end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if ({mem_read_ctrl, mem_write_ctrl, B, H} !== 4'b0) begin n_bad++; $display("FAIL reset strobes: got %b want 0000", {mem_read_ctrl, mem_write_ctrl, B, H}); end
        n_cmp++; if ({mem_address, addr_allign} !== '0) begin n_bad++; $display("FAIL reset address: got %h want 0", {mem_address, addr_allign}); end
        n_cmp++; if (mem_data_write !== 32'h0) begin n_bad++; $display("FAIL reset wdata: got %h want 0", mem_data_write); end
        n_cmp++; if ({core_rsp_valid, core_rsp_err, dbg_rsp_valid, dbg_rsp_err} !== 4'b0) begin n_bad++; $display("FAIL reset rsp: got %b want 0000", {core_rsp_valid, core_rsp_err, dbg_rsp_valid, dbg_rsp_err}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (dbg_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset dbg_ready: got %b want 0", dbg_req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        mem_model[2] = 32'h80FF_7F01;
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 17'h8, $urandom, "word_read");
        mem_model[1] = 32'h00A5_0000;
        run_txn(1'b0, 1'b0, 2'b00, 1'b0, 17'h6, $urandom, "byte_signed");
        run_txn(1'b0, 1'b0, 2'b00, 1'b1, 17'h6, $urandom, "byte_unsigned");
        run_txn(1'b0, 1'b1, 2'b01, 1'b0, 17'hE, 32'h1234_BEEF, "half_write");
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 17'h5, $urandom, "word_misalign");
        run_txn(1'b0, 1'b0, 2'b01, 1'b0, 17'h3, $urandom, "half_misalign");
        run_txn(1'b0, 1'b1, 2'b11, 1'b0, 17'h0, $urandom, "size_rsvd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(DBG_EN && $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    17'($urandom_range(0, 255)), $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        bit grants [$];
        bit dbg_seen;
        apply_reset();
        @(negedge clk);
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_size = 2'b10; core_req_addr = 17'h10;
        dbg_req_valid  = 1'b1; dbg_req_we  = 1'b0; dbg_req_size  = 2'b10; dbg_req_addr  = 17'h20;
        dbg_seen = 1'b0;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            #1;
            if (dbg_req_ready === 1'b1) dbg_seen = 1'b1;
            if (core_req_ready === 1'b1) grants.push_back(1'b0);
            else if (dbg_req_ready === 1'b1) grants.push_back(1'b1);
            @(negedge clk);
        end
        core_req_valid = 1'b0; dbg_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (grants.size() != 4) begin
            n_bad++; $display("FAIL arb count: got %0d grants want 4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (grants[i] !== (DBG_EN && (i % 2 == 1))) begin
                    n_bad++; $display("FAIL arb grant%0d: got dbg=%b want dbg=%b", i, grants[i], DBG_EN && (i % 2 == 1));
                end
            end
        end
        if (!DBG_EN) begin
            n_cmp++; if (dbg_seen !== 1'b0) begin n_bad++; $display("FAIL arb dbg_ready: got 1 want 0"); end
        end
    endtask

    task automatic test_reset_abort();
        mem_model[4] = 32'hCAFE_F00D;
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 17'h10, 32'h0, "pre_abort");
        @(negedge clk);
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_size = 2'b10; core_req_addr = 17'h10;
        #1;
        while (core_req_ready !== 1'b1) @(negedge clk);
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        n_cmp++; if (mem_read_ctrl !== 1'b1) begin n_bad++; $display("FAIL abort in_access: got %b want 1", mem_read_ctrl); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_read_ctrl, mem_write_ctrl} !== 2'b00) begin n_bad++; $display("FAIL abort strobes: got %b want 00", {mem_read_ctrl, mem_write_ctrl}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL abort rdata: got %h want 0", rsp_rdata); end
        repeat (2) begin
            @(posedge clk); #1;
            n_cmp++; if (core_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort rsp_valid: got %b want 0", core_rsp_valid); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 17'h10, 32'h0, "post_abort");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
